// File: rtl/pt_feedback_pkg.sv
// Shared types for the pt_feedback routing path: route codes and the
// route-change FSM states.
package pt_feedback_pkg;

  localparam logic [1:0] ROUTE_OFF = 2'b00;
  localparam logic [1:0] ROUTE_D0  = 2'b01;
  localparam logic [1:0] ROUTE_D1  = 2'b10;
  localparam logic [1:0] ROUTE_SUM = 2'b11;

  localparam int NUM_OUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUTE,
    APPLY,
    SETTLE
  } state_e;

endpackage

// File: rtl/sat_trunc.sv
// Signed width reduction: clamps to the OUT_W range and flags any clipping.
module sat_trunc #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  // The value fits when every bit above the output sign bit copies it.
  logic [IN_W-OUT_W:0] w_hi;
  assign w_hi  = i_data[IN_W-1:OUT_W-1];
  assign o_sat = !((&w_hi) || !(|w_hi));

  always_comb begin
    o_data = i_data[OUT_W-1:0];
    if (o_sat) begin
      if (i_data[IN_W-1]) o_data = {1'b1, {(OUT_W-1){1'b0}}};
      else                o_data = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conditional_router_2x8.sv
// Routes two signed sums onto eight saturated channels with click-free route changes.
// Define CONDITIONAL_ROUTER_STICKY_SAT_EN for sticky sat_o bits with sat_clear_i.
module conditional_router_2x8
  import pt_feedback_pkg::*;
#(
  parameter int INPUT_WIDTH  = 17,
  parameter int OUTPUT_WIDTH = 14,
  parameter int MUTE_CYCLES  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [15:0]                    route_sel_i,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
`ifdef CONDITIONAL_ROUTER_STICKY_SAT_EN
  input  logic                           sat_clear_i,
`endif
  input  logic signed [INPUT_WIDTH-1:0]  data0_i,
  input  logic signed [INPUT_WIDTH-1:0]  data1_i,
  output logic signed [OUTPUT_WIDTH-1:0] data0_o,
  output logic signed [OUTPUT_WIDTH-1:0] data1_o,
  output logic signed [OUTPUT_WIDTH-1:0] data2_o,
  output logic signed [OUTPUT_WIDTH-1:0] data3_o,
  output logic signed [OUTPUT_WIDTH-1:0] data4_o,
  output logic signed [OUTPUT_WIDTH-1:0] data5_o,
  output logic signed [OUTPUT_WIDTH-1:0] data6_o,
  output logic signed [OUTPUT_WIDTH-1:0] data7_o,
  output logic [NUM_OUT-1:0]             sat_o
);

  localparam int SW = INPUT_WIDTH + 1;
  localparam int CW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;

  function automatic logic signed [SW-1:0] route_mux(
    input logic [1:0]                   code,
    input logic signed [INPUT_WIDTH-1:0] a,
    input logic signed [INPUT_WIDTH-1:0] b
  );
    logic signed [SW-1:0] ea;
    logic signed [SW-1:0] eb;
    ea = {a[INPUT_WIDTH-1], a};
    eb = {b[INPUT_WIDTH-1], b};
    case (code)
      ROUTE_D0:  route_mux = ea;
      ROUTE_D1:  route_mux = eb;
      ROUTE_SUM: route_mux = ea + eb;
      default:   route_mux = '0;
    endcase
  endfunction

  state_e                   r_state;
  logic [15:0]              r_active;
  logic [15:0]              r_pending;
  logic [NUM_OUT-1:0]       r_mask;
  logic [CW-1:0]            r_cnt;
  logic                     r_cfg_ready;

  logic signed [SW-1:0]           r_sum_p1  [NUM_OUT];
  logic signed [OUTPUT_WIDTH-1:0] r_data_p2 [NUM_OUT];
  logic [NUM_OUT-1:0]             r_sat_p2;

  logic signed [OUTPUT_WIDTH-1:0] w_trunc [NUM_OUT];
  logic [NUM_OUT-1:0]             w_clip;
  logic [NUM_OUT-1:0]             w_diff;
  logic [NUM_OUT-1:0]             w_mute;
  logic [NUM_OUT-1:0]             w_sat_new;
  logic                           w_xfer;

  assign w_xfer    = cfg_valid_i && r_cfg_ready;
  assign w_mute    = (r_state != IDLE) ? r_mask : '0;
  assign w_sat_new = w_clip & ~w_mute;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    assign w_diff[k] = (route_sel_i[2*k +: 2] != r_active[2*k +: 2]);

    sat_trunc #(
      .IN_W  (SW),
      .OUT_W (OUTPUT_WIDTH)
    ) u_sat (
      .i_data (r_sum_p1[k]),
      .o_data (w_trunc[k]),
      .o_sat  (w_clip[k])
    );
  end

  // Route-change FSM: only outputs whose code changes are muted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer && (w_diff != '0)) begin
            r_pending   <= route_sel_i;
            r_mask      <= w_diff;
            r_cnt       <= CW'(MUTE_CYCLES - 1);
            r_state     <= MUTE;
            r_cfg_ready <= 1'b0;
          end
        end
        MUTE: begin
          if (r_cnt == '0) r_state <= APPLY;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        APPLY: begin
          r_active <= r_pending;
          r_state  <= SETTLE;
        end
        SETTLE: begin
          r_state     <= IDLE;
          r_mask      <= '0;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stage p1: select/sum; stage p2: saturate and mute.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        r_sum_p1[k]  <= '0;
        r_data_p2[k] <= '0;
      end
      r_sat_p2 <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        r_sum_p1[k]  <= route_mux(r_active[2*k +: 2], data0_i, data1_i);
        r_data_p2[k] <= w_mute[k] ? '0 : w_trunc[k];
      end
`ifdef CONDITIONAL_ROUTER_STICKY_SAT_EN
      r_sat_p2 <= (r_sat_p2 & ~{NUM_OUT{sat_clear_i}}) | w_sat_new;
`else
      r_sat_p2 <= w_sat_new;
`endif
    end
  end

  assign cfg_ready_o = r_cfg_ready;
  assign sat_o       = r_sat_p2;
  assign data0_o     = r_data_p2[0];
  assign data1_o     = r_data_p2[1];
  assign data2_o     = r_data_p2[2];
  assign data3_o     = r_data_p2[3];
  assign data4_o     = r_data_p2[4];
  assign data5_o     = r_data_p2[5];
  assign data6_o     = r_data_p2[6];
  assign data7_o     = r_data_p2[7];

endmodule

// File: tb/tb_conditional_router_2x8.sv
// Directed bench for conditional_router_2x8 (default parameters).
module tb_conditional_router_2x8;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic [15:0]        route_sel = '0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic signed [16:0] d0 = '0;
  logic signed [16:0] d1 = '0;
  logic signed [13:0] dout [8];
  logic [7:0]         sat;
`ifdef CONDITIONAL_ROUTER_STICKY_SAT_EN
  logic               sat_clr = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  conditional_router_2x8 dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .route_sel_i (route_sel),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
`ifdef CONDITIONAL_ROUTER_STICKY_SAT_EN
    .sat_clear_i (sat_clr),
`endif
    .data0_i     (d0),
    .data1_i     (d1),
    .data0_o     (dout[0]),
    .data1_o     (dout[1]),
    .data2_o     (dout[2]),
    .data3_o     (dout[3]),
    .data4_o     (dout[4]),
    .data5_o     (dout[5]),
    .data6_o     (dout[6]),
    .data7_o     (dout[7]),
    .sat_o       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   d0;
    int   d1;
    int   e0;
    int   e1;
    int   es;
    logic s0;
    logic s1;
    logic ss;
  } vec_t;

  vec_t tbl [8];
  int   codes [8];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_timeout", int'(cfg_ready), 1);
  endtask

  task automatic xfer(input logic [15:0] r);
    wait_ready();
    route_sel = r;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic set_route(input logic [15:0] r);
    xfer(r);
    wait_ready();
    tick(3);
  endtask

  initial begin
    int zeros2, rdy_low, bad5, exp, sv;
    // d0, d1, data0 result, data1 result, sum result, sat flags
    tbl[0] = '{100,    -50,    100,   -50,   50,    1'b0, 1'b0, 1'b0};
    tbl[1] = '{8191,   1,      8191,  1,     8191,  1'b0, 1'b0, 1'b1};
    tbl[2] = '{-8192,  -1,     -8192, -1,    -8192, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8192,   -8193,  8191,  -8192, -1,    1'b1, 1'b1, 1'b0};
    tbl[4] = '{60000,  60000,  8191,  8191,  8191,  1'b1, 1'b1, 1'b1};
    tbl[5] = '{-60000, -60000, -8192, -8192, -8192, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{0,      0,      0,     0,     0,     1'b0, 1'b0, 1'b0};
    tbl[7] = '{5000,   4000,   5000,  4000,  8191,  1'b0, 1'b0, 1'b1};
    // route 16'hE7C9 by output 0..7
    codes = '{1, 2, 0, 3, 3, 1, 2, 3};

    tick(3);
    for (int k = 0; k < 8; k++) chk($sformatf("rst_data%0d", k), int'(dout[k]), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    rst_ni = 1'b1;
    tick(2);
    chk("post_rst_ready", int'(cfg_ready), 1);

    // Route data0 to output 0.
    set_route(16'h0001);
    d0 = 17'sd100;
    tick(2);
    chk("r01_out0", int'(dout[0]), 100);
    for (int k = 1; k < 8; k++) chk($sformatf("r01_out%0d", k), int'(dout[k]), 0);

    // Table of steady-state vectors on a route using every code.
    set_route(16'hE7C9);
    for (int i = 0; i < 8; i++) begin
      d0 = tbl[i].d0[16:0];
      d1 = tbl[i].d1[16:0];
      tick(2);
      for (int k = 0; k < 8; k++) begin
        case (codes[k])
          1: begin exp = tbl[i].e0; sv = int'(tbl[i].s0); end
          2: begin exp = tbl[i].e1; sv = int'(tbl[i].s1); end
          3: begin exp = tbl[i].es; sv = int'(tbl[i].ss); end
          default: begin exp = 0; sv = 0; end
        endcase
        chk($sformatf("v%0d_data%0d", i, k), int'(dout[k]), exp);
        chk($sformatf("v%0d_sat%0d", i, k), int'(sat[k]), sv);
      end
    end

`ifdef CONDITIONAL_ROUTER_STICKY_SAT_EN
    sat_clr = 1'b0;
    d0 = '0;
    d1 = 17'sd60000;
    tick(2);
    chk("sticky_set", int'(sat[1]), 1);
    d1 = '0;
    tick(3);
    chk("sticky_hold", int'(sat[1]), 1);
    chk("sticky_hold_data", int'(dout[1]), 0);
    sat_clr = 1'b1;
    tick();
    chk("sticky_clear", int'(sat[1]), 0);
    d1 = 17'sd60000;
    tick(2);
    chk("sticky_set_wins", int'(sat[1]), 1);
`endif

    // Change output 2 from data0 to data1 while output 5 keeps data0.
    set_route(16'h0410);
    d0 = 17'sd1000;
    d1 = -17'sd2000;
    tick(3);
    chk("pre_mute_out2", int'(dout[2]), 1000);
    xfer(16'h0420);
    zeros2 = 0; rdy_low = 0; bad5 = 0;
    for (int i = 0; i < 19; i++) begin
      if (dout[2] == 0) zeros2++;
      if (!cfg_ready) rdy_low++;
      if (dout[5] != 14'sd1000) bad5++;
      tick();
    end
    chk("mute_zero_cycles", zeros2, 18);
    chk("mute_ready_low", rdy_low, 18);
    chk("mute_out5_glitches", bad5, 0);
    chk("mute_new_route_out2", int'(dout[2]), -2000);

    // Identical request: no mute, no ready drop.
    xfer(16'h0420);
    zeros2 = 0; rdy_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (dout[2] == 0 || dout[5] == 0) zeros2++;
      if (!cfg_ready) rdy_low++;
      tick();
    end
    chk("same_route_zeros", zeros2, 0);
    chk("same_route_ready_low", rdy_low, 0);

    // Reset in the middle of MUTE.
    xfer(16'hFFFF);
    tick(5);
    chk("busy_ready", int'(cfg_ready), 0);
    rst_ni = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("midrst_data%0d", k), int'(dout[k]), 0);
    chk("midrst_ready", int'(cfg_ready), 1);
    tick();
    rst_ni = 1'b1;
    tick(3);
    chk("after_rst_out5", int'(dout[5]), 0);
    chk("after_rst_out2", int'(dout[2]), 0);
    tick(25);
    zeros2 = 0;
    for (int k = 0; k < 8; k++) if (dout[k] != 0) zeros2++;
    chk("after_rst_all_off", zeros2, 0);
    chk("after_rst_ready", int'(cfg_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
